// File: rtl/alu_mc_if.sv
// Request/response bundle for the multi-cycle ALU: operands and start in,
// registered results, HI/LO and the busy/done handshake out.
interface alu_mc_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [1:0]       dbg_state;

    // start is sampled only while busy=0; done pulses once per accepted op.
    modport master (
        output start, a, b, alu_control,
        input  result, zero, hi, lo, busy, done, div_by_zero, dbg_state
    );

    modport slave (
        input  start, a, b, alu_control,
        output result, zero, hi, lo, busy, done, div_by_zero, dbg_state
    );
endinterface

// File: rtl/alu_mc.sv
// Registered EX-stage ALU: single-cycle logic/arithmetic ops plus iterative
// multu (shift-add) and divu (restoring) writing HI/LO.
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mc_if.slave  bus
);
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLTU  = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               zero_q, zero_d;
    logic               done_q, done_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH-1:0]   alu_res;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        alu_res = bus.a + bus.b;
        case (bus.alu_control)
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_XOR:  alu_res = bus.a ^ bus.b;
            OP_SUB:  alu_res = bus.a - bus.b;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            OP_NOR:  alu_res = ~(bus.a | bus.b);
            default: alu_res = bus.a + bus.b;
        endcase
    end

    // acc holds {upper, lower}: product/multiplier for MUL, remainder/quotient for DIV.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opnd_d   = opnd_q;
        acc_d    = acc_q;
        result_d = result_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = dbz_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.alu_control == OP_MULTU) begin
                        opnd_d  = bus.a;
                        acc_d   = {{WIDTH{1'b0}}, bus.b};
                        cnt_d   = CNT_W'(WIDTH);
                        state_d = MUL;
                    end else if (bus.alu_control == OP_DIVU) begin
                        if (bus.b == '0) begin
                            hi_d     = bus.a;
                            lo_d     = '1;
                            result_d = '1;
                            dbz_d    = 1'b1;
                            done_d   = 1'b1;
                        end else begin
                            opnd_d  = bus.b;
                            acc_d   = {{WIDTH{1'b0}}, bus.a};
                            cnt_d   = CNT_W'(WIDTH);
                            state_d = DIV;
                        end
                    end else begin
                        result_d = alu_res;
                        done_d   = 1'b1;
                    end
                end
            end
            MUL, DIV: begin
                acc_d = (state_q == MUL) ? mul_next : div_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    hi_d     = acc_d[2*WIDTH-1:WIDTH];
                    lo_d     = acc_d[WIDTH-1:0];
                    result_d = acc_d[WIDTH-1:0];
                    if (state_q == DIV) begin
                        dbz_d = 1'b0;
                    end
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        zero_d = (result_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b1;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opnd_q   <= opnd_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.result      = result_q;
    assign bus.zero        = zero_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_alu_mc.sv
// Directed plus random checks of alu_mc at WIDTH=32 and WIDTH=8 against an
// arithmetic reference model feeding an expected-result queue.
module tb_alu_mc;
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLTU  = 4'b0111;
    localparam logic [3:0] OP_NOR   = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    exp_t        exp_q[$];
    logic [31:0] m_hi[2];
    logic [31:0] m_lo[2];
    logic        m_dbz[2];
    logic [3:0]  rnd_ops[6] = '{OP_ADD, OP_SUB, OP_MULTU, OP_DIVU, OP_SLTU, OP_NOR};

    alu_mc_if #(.WIDTH(32)) bus32();
    alu_mc_if #(.WIDTH(8))  bus8();

    alu_mc #(.WIDTH(32), .CNT_W(6)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    alu_mc #(.WIDTH(8),  .CNT_W(4)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

    logic [31:0] o_res[2], o_hi[2], o_lo[2];
    logic        o_zero[2], o_done[2], o_busy[2], o_dbz[2];
    logic [1:0]  o_st[2];
    assign o_res[0]  = bus32.result;        assign o_res[1]  = {24'd0, bus8.result};
    assign o_hi[0]   = bus32.hi;            assign o_hi[1]   = {24'd0, bus8.hi};
    assign o_lo[0]   = bus32.lo;            assign o_lo[1]   = {24'd0, bus8.lo};
    assign o_zero[0] = bus32.zero;          assign o_zero[1] = bus8.zero;
    assign o_done[0] = bus32.done;          assign o_done[1] = bus8.done;
    assign o_busy[0] = bus32.busy;          assign o_busy[1] = bus8.busy;
    assign o_dbz[0]  = bus32.div_by_zero;   assign o_dbz[1]  = bus8.div_by_zero;
    assign o_st[0]   = bus32.dbg_state;     assign o_st[1]   = bus8.dbg_state;

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 50000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic s, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        if (sel == 1) begin
            bus8.start = s; bus8.alu_control = op; bus8.a = a[7:0]; bus8.b = b[7:0];
        end else begin
            bus32.start = s; bus32.alu_control = op; bus32.a = a; bus32.b = b;
        end
    endtask

    // reference model: pushes the expected completion of one accepted op
    task automatic push_exp(input int sel, input logic [3:0] op,
                            input logic [31:0] a, input logic [31:0] b);
        int          w;
        logic [63:0] mask, p;
        exp_t        e;
        w    = (sel == 1) ? 8 : 32;
        mask = (64'd1 << w) - 64'd1;
        e.hi = m_hi[sel]; e.lo = m_lo[sel]; e.dbz = m_dbz[sel];
        case (op)
            OP_AND:  p = {32'd0, a & b};
            OP_OR:   p = {32'd0, a | b};
            OP_XOR:  p = {32'd0, a ^ b};
            OP_SUB:  p = {32'd0, a} - {32'd0, b};
            OP_SLTU: p = (a < b) ? 64'd1 : 64'd0;
            OP_NOR:  p = ~{32'd0, a | b};
            OP_MULTU: begin
                p    = {32'd0, a} * {32'd0, b};
                e.hi = 32'((p >> w) & mask);
                e.lo = 32'(p & mask);
                p    = {32'd0, e.lo};
            end
            OP_DIVU: begin
                if (b == 0) begin
                    e.hi = a; e.lo = 32'(mask); e.dbz = 1'b1; p = mask;
                end else begin
                    e.hi = a % b; e.lo = a / b; e.dbz = 1'b0; p = {32'd0, e.lo};
                end
            end
            default: p = {32'd0, a} + {32'd0, b};
        endcase
        e.res  = 32'(p & mask);
        e.zero = (e.res == 32'd0);
        m_hi[sel] = e.hi; m_lo[sel] = e.lo; m_dbz[sel] = e.dbz;
        exp_q.push_back(e);
    endtask

    function automatic int lat_exp(input int sel, input logic [3:0] op, input logic [31:0] b);
        logic [31:0] bm;
        bm = (sel == 1) ? (b & 32'hFF) : b;
        if (op == OP_MULTU || (op == OP_DIVU && bm != 0)) return ((sel == 1) ? 8 : 32) + 1;
        return 1;
    endfunction

    // driver: present op on a negedge (or right now), deassert after acceptance edge
    task automatic issue(input int sel, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input bit now);
        logic [31:0] am, bm;
        am = (sel == 1) ? (a & 32'hFF) : a;
        bm = (sel == 1) ? (b & 32'hFF) : b;
        if (!now) @(negedge clk);
        set_in(sel, 1'b1, op, am, bm);
        push_exp(sel, op, am, bm);
        @(posedge clk);
        #1;
        set_in(sel, 1'b0, 4'($urandom), $urandom, $urandom);
    endtask

    // scoreboard: wait for done, check timing, pop and compare
    task automatic wait_done(input int sel, input string tag, input int exp_cyc,
                             input bit poke, input bit check_drop);
        int   n;
        int   busy_cnt;
        bit   seen;
        exp_t e;
        n = 0; busy_cnt = 0; seen = 1'b0;
        while (!seen && n < 200) begin
            @(negedge clk);
            n++;
            if (o_done[sel]) seen = 1'b1;
            else begin
                if (o_busy[sel]) busy_cnt++;
                if (poke && n == 5) set_in(sel, 1'b1, OP_ADD, 32'd1, 32'd1);
                if (poke && n == 6) set_in(sel, 1'b0, OP_ADD, 32'd0, 32'd0);
            end
        end
        chk({tag, ":done_seen"}, 32'(seen), 32'd1);
        chk({tag, ":done_cycle"}, n, exp_cyc);
        chk({tag, ":busy_cycles"}, busy_cnt, exp_cyc - 1);
        chk({tag, ":queue"}, exp_q.size(), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, ":result"}, o_res[sel], e.res);
            chk({tag, ":zero"}, 32'(o_zero[sel]), 32'(e.zero));
            chk({tag, ":hi"}, o_hi[sel], e.hi);
            chk({tag, ":lo"}, o_lo[sel], e.lo);
            chk({tag, ":dbz"}, 32'(o_dbz[sel]), 32'(e.dbz));
        end
        chk({tag, ":busy_at_done"}, 32'(o_busy[sel]), 32'd0);
        chk({tag, ":state_at_done"}, 32'(o_st[sel]), 32'd0);
        if (check_drop) begin
            @(negedge clk);
            chk({tag, ":done_one_cycle"}, 32'(o_done[sel]), 32'd0);
        end
    endtask

    task automatic op_chk(input int sel, input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        issue(sel, op, a, b, 1'b0);
        wait_done(sel, tag, lat_exp(sel, op, b), 1'b0, 1'b1);
    endtask

    task automatic check_reset_state(input string tag);
        for (int s = 0; s < 2; s++) begin
            chk({tag, ":result"}, o_res[s], 32'd0);
            chk({tag, ":zero"}, 32'(o_zero[s]), 32'd1);
            chk({tag, ":hi"}, o_hi[s], 32'd0);
            chk({tag, ":lo"}, o_lo[s], 32'd0);
            chk({tag, ":busy"}, 32'(o_busy[s]), 32'd0);
            chk({tag, ":done"}, 32'(o_done[s]), 32'd0);
            chk({tag, ":dbz"}, 32'(o_dbz[s]), 32'd0);
            chk({tag, ":state"}, 32'(o_st[s]), 32'd0);
        end
    endtask

    initial begin
        int          pulses;
        logic [3:0]  op;
        logic [31:0] ra, rb;

        // reset
        rst_n = 1'b0;
        set_in(0, 1'b0, OP_AND, 32'd0, 32'd0);
        set_in(1, 1'b0, OP_AND, 32'd0, 32'd0);
        for (int s = 0; s < 2; s++) begin m_hi[s] = 0; m_lo[s] = 0; m_dbz[s] = 0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        // single-cycle ops
        op_chk(0, "add_7_5", OP_ADD, 32'd7, 32'd5);
        op_chk(0, "sub_5_5", OP_SUB, 32'd5, 32'd5);
        op_chk(0, "sltu_big_1", OP_SLTU, 32'hFFFF_FFFF, 32'd1);
        op_chk(0, "sltu_1_big", OP_SLTU, 32'd1, 32'hFFFF_FFFF);
        op_chk(0, "default_0101", 4'b0101, 32'd3, 32'd4);
        op_chk(0, "sub_wrap", OP_SUB, 32'd0, 32'd1);
        op_chk(0, "and", OP_AND, $urandom, $urandom);
        op_chk(0, "or", OP_OR, $urandom, $urandom);
        op_chk(0, "xor", OP_XOR, $urandom, $urandom);
        op_chk(0, "nor", OP_NOR, $urandom, $urandom);

        // multu with an ignored mid-operation start
        issue(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(0, "mul_max", 33, 1'b1, 1'b1);

        // divu normal, by zero, then clear of the flag
        op_chk(0, "divu_100_7", OP_DIVU, 32'd100, 32'd7);
        op_chk(0, "divu_9_0", OP_DIVU, 32'd9, 32'd0);
        op_chk(0, "divu_clear", OP_DIVU, 32'hDEAD_BEEF, 32'd3);
        op_chk(0, "divu_small_big", OP_DIVU, 32'd5, 32'hFFFF_FFF0);

        for (int i = 0; i < 6; i++) begin
            op = rnd_ops[$urandom_range(0, 5)];
            ra = $urandom;
            rb = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
            op_chk(0, "rnd32", op, ra, rb);
        end

        // reset in the middle of a multu
        issue(0, OP_MULTU, $urandom, $urandom, 1'b0);
        repeat (9) @(negedge clk);
        chk("midrst:busy_before", 32'(o_busy[0]), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_state("midrst");
        rst_n = 1'b1;
        exp_q.delete();
        for (int s = 0; s < 2; s++) begin m_hi[s] = 0; m_lo[s] = 0; m_dbz[s] = 0; end
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_done[0]) pulses++;
        end
        chk("midrst:no_done", pulses, 32'd0);
        op_chk(0, "add_after_rst", OP_ADD, 32'd40, 32'd2);

        // WIDTH=8 instance, then back-to-back add in the done cycle
        issue(1, OP_MULTU, 32'd200, 32'd200, 1'b0);
        wait_done(1, "mul8_200_200", 9, 1'b0, 1'b0);
        issue(1, OP_ADD, 32'h33, 32'h44, 1'b1);
        wait_done(1, "b2b_add8", 1, 1'b0, 1'b1);
        op_chk(1, "add8_wrap", OP_ADD, 32'hF0, 32'h20);
        op_chk(1, "divu8_255_16", OP_DIVU, 32'd255, 32'd16);

        for (int i = 0; i < 8; i++) begin
            op = rnd_ops[$urandom_range(0, 5)];
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            op_chk(1, "rnd8", op, ra, rb);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
